// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised single-clock FIFO with registered or first-word-fall-through read
module param_fifo #(
    parameter int BIT_DEPTH   = 32,
    parameter int FIFO_VOLUME = 8,
    parameter int AF_LEVEL    = 6,
    parameter int AE_LEVEL    = 2,
    parameter int FWFT        = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable_write,
    input  logic [BIT_DEPTH-1:0]           value_to_write,
    input  logic                           enable_read,
    output logic [BIT_DEPTH-1:0]           value_to_read,
    output logic                           read_valid,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [$clog2(FIFO_VOLUME):0]   count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int AW = $clog2(FIFO_VOLUME);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(FIFO_VOLUME);

    logic [BIT_DEPTH-1:0] mem_q [FIFO_VOLUME];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [BIT_DEPTH-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic                 wr_acc, rd_acc;

    always_comb begin
        rd_acc   = enable_read && !empty_q && ((FWFT == 0) || rvalid_q);
        // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
        wr_acc   = enable_write && (!full_q || rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (FWFT != 0) begin
            rvalid_d = (count_d != '0);
            // Next head is the word being written now when it lands exactly at the new read pointer.
            if (rvalid_d) begin
                rdata_d = (wr_acc && (rd_ptr_d == wr_ptr_q)) ? value_to_write : mem_q[rd_ptr_d];
            end
        end else if (rd_acc) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= value_to_write;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= (AF_LEVEL == 0);
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            full_q   <= (count_d == CNT_MAX);
            empty_q  <= (count_d == '0);
            af_q     <= (32'(count_d) >= 32'(AF_LEVEL));
            ae_q     <= (32'(count_d) <= 32'(AE_LEVEL));
            ovf_q    <= enable_write && !wr_acc;
            unf_q    <= enable_read && !rd_acc;
        end
    end

    assign value_to_read = rdata_q;
    assign read_valid    = rvalid_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign almost_full   = af_q;
    assign almost_empty  = ae_q;
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - randomized and directed bench for param_fifo in standard and FWFT modes
module tb_param_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        wa, ra;
    logic [31:0] da, a_data;
    logic        a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [3:0]  a_cnt;

    logic        wb, rb;
    logic [15:0] db, b_data;
    logic        b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0]  b_cnt;

    param_fifo #(.BIT_DEPTH(32), .FIFO_VOLUME(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst), .enable_write(wa), .value_to_write(da), .enable_read(ra),
        .value_to_read(a_data), .read_valid(a_valid), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
    );

    param_fifo #(.BIT_DEPTH(16), .FIFO_VOLUME(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut_b (
        .clk(clk), .rst(rst), .enable_write(wb), .value_to_write(db), .enable_read(rb),
        .value_to_read(b_data), .read_valid(b_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] qa[$];
    logic [31:0] ea_data;
    bit          ea_valid, ea_ovf, ea_unf;
    logic [15:0] qb[$];
    logic [15:0] eb_data;
    bit          eb_valid, eb_ovf, eb_unf;

    wire [10:0] a_obs = {a_cnt, a_full, a_empty, a_af, a_ae, a_ovf, a_unf, a_valid};
    wire [9:0]  b_obs = {b_cnt, b_full, b_empty, b_af, b_ae, b_ovf, b_unf, b_valid};

    function automatic logic [10:0] a_exp();
        int n = qa.size();
        return {4'(n), n == 8, n == 0, n >= 6, n <= 2, ea_ovf, ea_unf, ea_valid};
    endfunction

    function automatic logic [9:0] b_exp();
        int n = qb.size();
        return {3'(n), n == 4, n == 0, n >= 3, n <= 1, eb_ovf, eb_unf, eb_valid};
    endfunction

    // Reference for the standard-read FIFO: a queue, popped word appears one cycle later.
    task automatic step_a(input bit w, input logic [31:0] d, input bit r);
        bit racc, wacc;
        wa = w; da = d; ra = r; wb = 1'b0; rb = 1'b0;
        @(posedge clk);
        racc = r && (qa.size() > 0);
        wacc = w && ((qa.size() < 8) || racc);
        ea_valid = racc;
        if (racc) ea_data = qa.pop_front();
        if (wacc) qa.push_back(d);
        ea_ovf = w && !wacc;
        ea_unf = r && !racc;
        eb_ovf = 1'b0; eb_unf = 1'b0;
        #1;
        wa = 1'b0; ra = 1'b0;
    endtask

    // Reference for the FWFT FIFO: output is always the queue head while non-empty.
    task automatic step_b(input bit w, input logic [15:0] d, input bit r);
        bit racc, wacc;
        wb = w; db = d; rb = r; wa = 1'b0; ra = 1'b0;
        @(posedge clk);
        racc = r && (qb.size() > 0);
        wacc = w && ((qb.size() < 4) || racc);
        if (racc) void'(qb.pop_front());
        if (wacc) qb.push_back(d);
        eb_valid = (qb.size() > 0);
        if (eb_valid) eb_data = qb[0];
        eb_ovf = w && !wacc;
        eb_unf = r && !racc;
        ea_ovf = 1'b0; ea_unf = 1'b0; ea_valid = 1'b0;
        #1;
        wb = 1'b0; rb = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; wa = 1'b0; ra = 1'b0; wb = 1'b0; rb = 1'b0; da = '0; db = '0;
        repeat (2) @(posedge clk);
        qa.delete(); qb.delete();
        ea_data = '0; ea_valid = 1'b0; ea_ovf = 1'b0; ea_unf = 1'b0;
        eb_data = '0; eb_valid = 1'b0; eb_ovf = 1'b0; eb_unf = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (a_obs !== a_exp()) begin
            tests_failed++; $display("FAIL reset_a_status got %h want %h", a_obs, a_exp());
        end
        tests_run++;
        if (a_data !== 32'h0) begin
            tests_failed++; $display("FAIL reset_a_data got %h want 0", a_data);
        end
        tests_run++;
        if (b_obs !== b_exp()) begin
            tests_failed++; $display("FAIL reset_b_status got %h want %h", b_obs, b_exp());
        end
        tests_run++;
        if (b_data !== 16'h0) begin
            tests_failed++; $display("FAIL reset_b_data got %h want 0", b_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            step_a(1'b1, 32'(i), 1'b0);
            tests_run++;
            if (a_obs !== a_exp()) begin
                tests_failed++; $display("FAIL fill_status[%0d] got %h want %h", i, a_obs, a_exp());
            end
        end
        tests_run++;
        if ({a_full, a_af, a_cnt} !== {1'b1, 1'b1, 4'd8}) begin
            tests_failed++; $display("FAIL fill_full got %b/%b/%0d want 1/1/8", a_full, a_af, a_cnt);
        end
        for (int i = 1; i <= 8; i++) begin
            step_a(1'b0, 32'h0, 1'b1);
            tests_run++;
            if (a_obs !== a_exp() || a_data !== 32'(i)) begin
                tests_failed++;
                $display("FAIL drain[%0d] got %h/%h want %h/%h", i, a_obs, a_data, a_exp(), 32'(i));
            end
        end
        step_a(1'b0, 32'h0, 1'b0);
        tests_run++;
        if ({a_empty, a_valid, a_data} !== {1'b1, 1'b0, 32'h8}) begin
            tests_failed++; $display("FAIL drain_end got %b/%b/%h want 1/0/8", a_empty, a_valid, a_data);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 8; i++) step_a(1'b1, 32'h10 + 32'(i), 1'b0);
        step_a(1'b1, 32'h9, 1'b0);
        tests_run++;
        if (a_ovf !== 1'b1 || a_cnt !== 4'd8) begin
            tests_failed++; $display("FAIL overflow got %b/%0d want 1/8", a_ovf, a_cnt);
        end
        step_a(1'b0, 32'h0, 1'b0);
        tests_run++;
        if (a_ovf !== 1'b0) begin
            tests_failed++; $display("FAIL overflow_pulse got %b want 0", a_ovf);
        end
        for (int i = 0; i < 8; i++) step_a(1'b0, 32'h0, 1'b1);
        step_a(1'b0, 32'h0, 1'b1);
        tests_run++;
        if (a_unf !== 1'b1 || a_data !== 32'h17 || a_valid !== 1'b0 || a_obs !== a_exp()) begin
            tests_failed++; $display("FAIL underflow got %b/%h/%b want 1/17/0", a_unf, a_data, a_valid);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) step_a(1'b1, 32'h40 + 32'(i), 1'b0);
        step_a(1'b1, 32'h100, 1'b1);
        tests_run++;
        if (a_obs !== a_exp() || a_cnt !== 4'd8 || a_ovf !== 1'b0 || a_data !== 32'h40) begin
            tests_failed++; $display("FAIL rw_full got %h/%h want %h/40", a_obs, a_data, a_exp());
        end
        for (int i = 0; i < 8; i++) step_a(1'b0, 32'h0, 1'b1);
        tests_run++;
        if (a_data !== 32'h100) begin
            tests_failed++; $display("FAIL rw_full_last got %h want 100", a_data);
        end
        step_a(1'b1, 32'h200, 1'b1);
        tests_run++;
        if (a_obs !== a_exp() || a_unf !== 1'b1 || a_cnt !== 4'd1) begin
            tests_failed++; $display("FAIL rw_empty got %h want %h", a_obs, a_exp());
        end
        step_a(1'b0, 32'h0, 1'b1);
        tests_run++;
        if (a_data !== 32'h200 || a_empty !== 1'b1) begin
            tests_failed++; $display("FAIL rw_empty_data got %h/%b want 200/1", a_data, a_empty);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step_a(1'b1, 32'h300 + 32'(i), 1'b0);
        for (int i = 3; i < 23; i++) begin
            step_a(1'b1, 32'h300 + 32'(i), 1'b1);
            tests_run++;
            if (a_obs !== a_exp() || a_data !== 32'h300 + 32'(i - 3)) begin
                tests_failed++;
                $display("FAIL wrap[%0d] got %h/%h want %h/%h", i, a_obs, a_data, a_exp(), 32'h300 + 32'(i - 3));
            end
        end
        for (int i = 0; i < 3; i++) step_a(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_random_std();
        int pw;
        for (int c = 0; c < 600; c++) begin
            pw = (c < 200) ? 75 : (c < 400) ? 25 : 50;
            step_a($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < (100 - pw));
            tests_run++;
            if (a_obs !== a_exp() || (ea_valid && a_data !== ea_data)) begin
                tests_failed++;
                $display("FAIL rand_std[%0d] got %h/%h want %h/%h", c, a_obs, a_data, a_exp(), ea_data);
            end
        end
    endtask

    task automatic test_fwft();
        step_b(1'b1, 16'hABCD, 1'b0);
        tests_run++;
        if (b_valid !== 1'b1 || b_data !== 16'hABCD || b_obs !== b_exp()) begin
            tests_failed++; $display("FAIL fwft_first got %b/%h want 1/abcd", b_valid, b_data);
        end
        step_b(1'b1, 16'h1234, 1'b0);
        step_b(1'b1, 16'h5678, 1'b0);
        step_b(1'b0, 16'h0, 1'b1);
        tests_run++;
        if (b_data !== 16'h1234 || b_cnt !== 3'd2 || b_obs !== b_exp()) begin
            tests_failed++; $display("FAIL fwft_pop got %h/%0d want 1234/2", b_data, b_cnt);
        end
        step_b(1'b1, 16'h1111, 1'b0);
        step_b(1'b1, 16'h2222, 1'b0);
        step_b(1'b1, 16'h3333, 1'b0);
        tests_run++;
        if (b_ovf !== 1'b1 || b_full !== 1'b1 || b_obs !== b_exp()) begin
            tests_failed++; $display("FAIL fwft_overflow got %b/%b want 1/1", b_ovf, b_full);
        end
        do_reset();
        tests_run++;
        if (b_obs !== b_exp() || b_empty !== 1'b1 || b_valid !== 1'b0) begin
            tests_failed++; $display("FAIL fwft_reset got %h want %h", b_obs, b_exp());
        end
        rst = 1'b1;
        step_b(1'b1, 16'h55AA, 1'b0);
        step_b(1'b0, 16'h0, 1'b1);
        tests_run++;
        if (b_empty !== 1'b1 || b_valid !== 1'b0 || b_obs !== b_exp()) begin
            tests_failed++; $display("FAIL fwft_after_reset got %b/%b want 1/0", b_empty, b_valid);
        end
        step_b(1'b1, 16'h0F0F, 1'b1);
        tests_run++;
        if (b_unf !== 1'b1 || b_data !== 16'h0F0F || b_valid !== 1'b1) begin
            tests_failed++; $display("FAIL fwft_rw_empty got %b/%h/%b want 1/0f0f/1", b_unf, b_data, b_valid);
        end
    endtask

    task automatic test_random_fwft();
        int pw;
        for (int c = 0; c < 600; c++) begin
            pw = (c < 200) ? 70 : (c < 400) ? 30 : 50;
            step_b($urandom_range(0, 99) < pw, 16'($urandom), $urandom_range(0, 99) < (100 - pw));
            tests_run++;
            if (b_obs !== b_exp() || (eb_valid && b_data !== eb_data)) begin
                tests_failed++;
                $display("FAIL rand_fwft[%0d] got %h/%h want %h/%h", c, b_obs, b_data, b_exp(), eb_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_wrap();
        test_random_std();
        test_fwft();
        test_random_fwft();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
